// File: rtl/hbm_stride_read.sv
`default_nettype none
// ============================================================================
//  Module   : hbm_stride_read
//  Purpose  : AXI4 read master for one HBM pseudo-channel. On start it issues
//             read_ops INCR bursts at base + k*stride. It accepts every R beat,
//             counts beats and errors, and pulses done when the final burst
//             completes.
//  Ports    : clk/rst            clock, asynchronous active-high reset
//             start_read         one-cycle start (ignored while busy)
//             read_ops/stride/init_addr/mem_burst_size   run configuration
//             busy/done          run status
//             beat_count/err_count   per-run statistics
//             m_axi_AR* / m_axi_R*   AXI4 read address and data channels
//             rd_checksum        XOR of accepted RDATA (RD_CHECKSUM_EN only)
//  Options  : define RD_CHECKSUM_EN to add the rd_checksum output
//  Revision : 1.0  initial release
// ============================================================================
module hbm_stride_read #(
   parameter int ENGINE_ID       = 0,
   parameter int ADDR_WIDTH      = 33,
   parameter int DATA_WIDTH      = 256,
   parameter int ID_WIDTH        = 5,
   parameter int MAX_OUTSTANDING = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_read,
   input  logic [31:0]           read_ops,
   input  logic [31:0]           stride,
   input  logic [ADDR_WIDTH-1:0] init_addr,
   input  logic [15:0]           mem_burst_size,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           beat_count,
   output logic [15:0]           err_count,
   output logic                  m_axi_ARVALID,
   output logic [ADDR_WIDTH-1:0] m_axi_ARADDR,
   output logic [ID_WIDTH-1:0]   m_axi_ARID,
   output logic [7:0]            m_axi_ARLEN,
   output logic [2:0]            m_axi_ARSIZE,
   output logic [1:0]            m_axi_ARBURST,
   output logic [1:0]            m_axi_ARLOCK,
   output logic [3:0]            m_axi_ARCACHE,
   output logic [2:0]            m_axi_ARPROT,
   output logic [3:0]            m_axi_ARQOS,
   output logic [3:0]            m_axi_ARREGION,
   input  logic                  m_axi_ARREADY,
   input  logic                  m_axi_RVALID,
   input  logic [DATA_WIDTH-1:0] m_axi_RDATA,
   input  logic [1:0]            m_axi_RRESP,
   input  logic                  m_axi_RLAST,
   input  logic [ID_WIDTH-1:0]   m_axi_RID,
   output logic                  m_axi_RREADY
`ifdef RD_CHECKSUM_EN
   ,
   output logic [DATA_WIDTH-1:0] rd_checksum
`endif
);

   localparam int               c_BEAT_SHIFT = $clog2(DATA_WIDTH / 8);
   localparam int               c_OUT_W      = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [3:0]       c_ENGINE     = 4'(ENGINE_ID);
   localparam logic [c_OUT_W-1:0] c_MAX_OUT  = c_OUT_W'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_next_state;

   logic [31:0]             r_ops;
   logic [31:0]             r_stride;
   logic [15:0]             r_burst_size;
   logic [ADDR_WIDTH-1:0]   r_base;
   logic [ADDR_WIDTH-1:0]   r_offset;
   logic [31:0]             r_ar_cnt;
   logic [31:0]             r_burst_cnt;
   logic [7:0]              r_beat_in_burst;
   logic [31:0]             r_beat_count;
   logic [15:0]             r_err_count;
   logic [c_OUT_W-1:0]      r_outstanding;
   logic                    r_arvalid;
   logic [ADDR_WIDTH-1:0]   r_araddr;
   logic                    r_done;

   logic [ADDR_WIDTH-1:0]   w_start_base;
   logic [15:0]             w_beats_m1;
   logic [7:0]              w_arlen;
   logic                    w_ar_hs;
   logic                    w_r_hs;
   logic                    w_last_exp;
   logic                    w_burst_done;
   logic                    w_final;
   logic                    w_out_dec;
   logic [31:0]             w_ar_cnt_n;
   logic [ADDR_WIDTH-1:0]   w_offset_n;
   logic [c_OUT_W-1:0]      w_out_n;
   logic                    w_arvalid_n;
   logic [1:0]              w_err_inc;
   logic [16:0]             w_err_sum;
   logic                    w_unused;

   // Engine select lives in address bits [31:28]; only the low 28 bits of
   // the supplied base are honoured.
   always_comb begin
      w_start_base        = '0;
      w_start_base[27:0]  = init_addr[27:0];
      w_start_base[31:28] = c_ENGINE;
   end

   assign w_beats_m1 = (r_burst_size >> c_BEAT_SHIFT) - 16'd1;
   assign w_arlen    = w_beats_m1[7:0];

   assign w_ar_hs      = r_arvalid & m_axi_ARREADY;
   assign w_r_hs       = m_axi_RVALID & m_axi_RREADY;
   assign w_last_exp   = (r_beat_in_burst == w_arlen);
   // Burst boundaries follow the beat counter, not RLAST, so a misbehaving
   // slave cannot desynchronise the completion accounting.
   assign w_burst_done = w_r_hs & w_last_exp;
   assign w_final      = w_burst_done & ((r_burst_cnt + 32'd1) == r_ops);
   assign w_out_dec    = w_burst_done & (r_outstanding != '0);

   assign w_ar_cnt_n = r_ar_cnt + {31'd0, w_ar_hs};
   assign w_offset_n = w_ar_hs ? (r_offset + ADDR_WIDTH'(r_stride)) : r_offset;
   assign w_out_n    = r_outstanding + {{(c_OUT_W-1){1'b0}}, w_ar_hs}
                                     - {{(c_OUT_W-1){1'b0}}, w_out_dec};
   // Next ARVALID looks at post-update counters so a fresh address is ready
   // on the cycle after a handshake without overshooting the window.
   assign w_arvalid_n = (w_next_state == S_RUN) && (w_ar_cnt_n < r_ops)
                        && (w_out_n < c_MAX_OUT);

   // RRESP error and RLAST mismatch are independent; a beat may add two.
   assign w_err_inc = {1'b0, (m_axi_RRESP != 2'b00)} + {1'b0, (m_axi_RLAST != w_last_exp)};
   assign w_err_sum = {1'b0, r_err_count} + {15'd0, w_err_inc};

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (start_read && (read_ops != 32'd0))
               w_next_state = S_RUN;
         end
         S_RUN: begin
            if (w_final)
               w_next_state = S_IDLE;
            else if (w_ar_cnt_n == r_ops)
               w_next_state = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_final)
               w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next_state;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ops           <= '0;
         r_stride        <= '0;
         r_burst_size    <= '0;
         r_base          <= '0;
         r_offset        <= '0;
         r_ar_cnt        <= '0;
         r_burst_cnt     <= '0;
         r_beat_in_burst <= '0;
         r_beat_count    <= '0;
         r_err_count     <= '0;
         r_outstanding   <= '0;
         r_arvalid       <= 1'b0;
         r_araddr        <= '0;
         r_done          <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == S_IDLE) begin
            r_arvalid <= 1'b0;
            if (start_read) begin
               r_ops           <= read_ops;
               r_stride        <= stride;
               r_burst_size    <= mem_burst_size;
               r_base          <= w_start_base;
               r_offset        <= '0;
               r_ar_cnt        <= '0;
               r_burst_cnt     <= '0;
               r_beat_in_burst <= '0;
               r_beat_count    <= '0;
               r_err_count     <= '0;
               r_outstanding   <= '0;
               // An empty run completes immediately without ever going busy.
               r_done          <= (read_ops == 32'd0);
            end
         end else begin
            // Address/valid only move when not stalled by the slave.
            if (!r_arvalid || m_axi_ARREADY) begin
               r_arvalid <= w_arvalid_n;
               if (w_arvalid_n)
                  r_araddr <= r_base + w_offset_n;
            end
            r_offset      <= w_offset_n;
            r_ar_cnt      <= w_ar_cnt_n;
            r_outstanding <= w_out_n;
            if (w_r_hs) begin
               r_beat_count    <= r_beat_count + 32'd1;
               r_err_count     <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
               r_beat_in_burst <= w_last_exp ? 8'd0 : (r_beat_in_burst + 8'd1);
               if (w_burst_done)
                  r_burst_cnt <= r_burst_cnt + 32'd1;
            end
            if (w_final)
               r_done <= 1'b1;
         end
      end
   end

`ifdef RD_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] r_checksum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_checksum <= '0;
      else if ((r_state == S_IDLE) && start_read)
         r_checksum <= '0;
      else if (w_r_hs)
         r_checksum <= r_checksum ^ m_axi_RDATA;
   end

   assign rd_checksum = r_checksum;
`endif

   assign busy           = (r_state != S_IDLE);
   assign done           = r_done;
   assign beat_count     = r_beat_count;
   assign err_count      = r_err_count;
   assign m_axi_ARVALID  = r_arvalid;
   assign m_axi_ARADDR   = r_araddr;
   assign m_axi_ARID     = '0;
   assign m_axi_ARLEN    = w_arlen;
   assign m_axi_ARSIZE   = 3'(c_BEAT_SHIFT);
   assign m_axi_ARBURST  = 2'b01;
   assign m_axi_ARLOCK   = 2'b00;
   assign m_axi_ARCACHE  = 4'b0000;
   assign m_axi_ARPROT   = 3'b010;
   assign m_axi_ARQOS    = 4'b0000;
   assign m_axi_ARREGION = 4'b0000;
   assign m_axi_RREADY   = (r_state != S_IDLE);

   assign w_unused = ^{m_axi_RID, m_axi_RDATA, init_addr[ADDR_WIDTH-1:28], w_beats_m1[15:8]};

endmodule
`default_nettype wire

// File: tb/tb_hbm_stride_read.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hbm_stride_read
//  Purpose  : Self-checking bench for hbm_stride_read (ENGINE_ID=2, 256-bit,
//             4 outstanding). A negedge-driven AXI slave model returns beats;
//             expected AR addresses are queued at start and popped on each
//             address handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hbm_stride_read;

   localparam int AW   = 33;
   localparam int DW   = 256;
   localparam int IW   = 5;
   localparam int MAXO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_read = 1'b0;
   logic [31:0]   read_ops = '0;
   logic [31:0]   stride = '0;
   logic [AW-1:0] init_addr = '0;
   logic [15:0]   mem_burst_size = '0;
   logic          busy, done;
   logic [31:0]   beat_count;
   logic [15:0]   err_count;
   logic          ARVALID, ARREADY;
   logic [AW-1:0] ARADDR;
   logic [IW-1:0] ARID, RID;
   logic [7:0]    ARLEN;
   logic [2:0]    ARSIZE, ARPROT;
   logic [1:0]    ARBURST, ARLOCK, RRESP;
   logic [3:0]    ARCACHE, ARQOS, ARREGION;
   logic          RVALID, RLAST, RREADY;
   logic [DW-1:0] RDATA;
`ifdef RD_CHECKSUM_EN
   logic [DW-1:0] rd_checksum;
`endif

   always #5 clk = ~clk;

   hbm_stride_read #(
      .ENGINE_ID(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk), .rst(rst), .start_read(start_read), .read_ops(read_ops),
      .stride(stride), .init_addr(init_addr), .mem_burst_size(mem_burst_size),
      .busy(busy), .done(done), .beat_count(beat_count), .err_count(err_count),
      .m_axi_ARVALID(ARVALID), .m_axi_ARADDR(ARADDR), .m_axi_ARID(ARID),
      .m_axi_ARLEN(ARLEN), .m_axi_ARSIZE(ARSIZE), .m_axi_ARBURST(ARBURST),
      .m_axi_ARLOCK(ARLOCK), .m_axi_ARCACHE(ARCACHE), .m_axi_ARPROT(ARPROT),
      .m_axi_ARQOS(ARQOS), .m_axi_ARREGION(ARREGION), .m_axi_ARREADY(ARREADY),
      .m_axi_RVALID(RVALID), .m_axi_RDATA(RDATA), .m_axi_RRESP(RRESP),
      .m_axi_RLAST(RLAST), .m_axi_RID(RID), .m_axi_RREADY(RREADY)
`ifdef RD_CHECKSUM_EN
      , .rd_checksum(rd_checksum)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s actual=missing required=present", name);
   endtask

   // ---------------- slave model state ----------------
   logic [32:0]   q_exp_addr[$];
   logic [7:0]    q_burst[$];
   int            ar_stall = 0, ar_stall_cnt = 0, ar_hs = 0;
   bit            r_rand = 0, r_block = 0, r_hold = 0, ar_wait = 0;
   int            rresp_beat = -1, flip_a = -1, flip_b = -1;
   int            g_beat = 0, bib = 0;
   logic [32:0]   ar_prev = '0;
   logic [7:0]    exp_arlen = '0;
   logic [DW-1:0] model_ck = '0;

   initial begin
      ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = 0; RLAST = 0; RID = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            q_burst.delete();
            RVALID = 0; ARREADY = 0; r_hold = 0; ar_wait = 0; ar_stall_cnt = 0; bib = 0;
         end else begin
            // R channel: hold an unaccepted beat, otherwise maybe present a new one
            if (!r_hold) begin
               if (q_burst.size() > 0 && !r_block && (!r_rand || $urandom_range(1) == 1)) begin
                  RVALID = 1;
                  RDATA  = 256'(1) << g_beat;
                  RRESP  = (g_beat == rresp_beat) ? 2'b10 : 2'b00;
                  RLAST  = (bib == int'(q_burst[0])) ^ (g_beat == flip_a || g_beat == flip_b);
               end else begin
                  RVALID = 0;
               end
            end
            if (RVALID && RREADY) begin
               model_ck ^= RDATA;
               g_beat++;
               if (bib == int'(q_burst[0])) begin
                  void'(q_burst.pop_front());
                  bib = 0;
               end else begin
                  bib++;
               end
               r_hold = 0;
            end else begin
               r_hold = RVALID;
            end
            // AR channel
            if (ARVALID) begin
               if (ar_wait) chk("ar_hold_addr", ARADDR, ar_prev);
               if (ar_stall_cnt < ar_stall) begin
                  ARREADY = 0; ar_stall_cnt++; ar_wait = 1; ar_prev = ARADDR;
               end else begin
                  ARREADY = 1; ar_stall_cnt = 0; ar_wait = 0; ar_hs++;
                  if (q_exp_addr.size() == 0) fail("ar_expected");
                  else chk("araddr", ARADDR, q_exp_addr.pop_front());
                  chk("arlen", ARLEN, exp_arlen);
                  q_burst.push_back(ARLEN);
               end
            end else begin
               if (ar_wait) chk("ar_hold_valid", ARVALID, 1);
               ARREADY = 0; ar_wait = 0;
            end
         end
      end
   end

   // ---------------- vectors ----------------
   typedef struct {
      int          ops;
      logic [31:0] strd;
      logic [31:0] init;
      int          burst;
      int          stall;
      bit          rrand;
      int          rresp_b;
      int          fa;
      int          fb;
      int          exp_beats;
      int          exp_err;
      int          exp_arlen;
   } vec_t;

   vec_t vecs[6];

   function automatic logic [32:0] calc_addr(input logic [31:0] init, input logic [31:0] strd, input int k);
      logic [32:0] b;
      b = {1'b0, 4'd2, init[27:0]};
      return b + 33'(k) * {1'b0, strd};
   endfunction

   task automatic push_addrs(input int ops, input logic [31:0] init, input logic [31:0] strd);
      for (int k = 0; k < ops; k++) q_exp_addr.push_back(calc_addr(init, strd, k));
   endtask

   task automatic wait_done(input string tag, output bit seen);
      seen = 0;
      for (int c = 0; c < 3000 && !seen; c++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      if (!seen) fail({tag, "_done_timeout"});
   endtask

   task automatic run_vec(input vec_t v, input int id);
      bit seen;
      ar_stall = v.stall; r_rand = v.rrand; rresp_beat = v.rresp_b;
      flip_a = v.fa; flip_b = v.fb; exp_arlen = 8'(v.exp_arlen);
      ar_hs = 0; g_beat = 0; model_ck = '0;
      push_addrs(v.ops, v.init, v.strd);
      @(negedge clk);
      start_read = 1; read_ops = 32'(v.ops); stride = v.strd;
      init_addr = 33'(v.init); mem_burst_size = 16'(v.burst);
      @(negedge clk);
      start_read = 0;
      chk($sformatf("busy_v%0d", id), busy, 1);
      wait_done($sformatf("v%0d", id), seen);
      if (seen) begin
         chk($sformatf("beat_count_v%0d", id), beat_count, 32'(v.exp_beats));
         chk($sformatf("err_count_v%0d", id), err_count, 16'(v.exp_err));
         chk($sformatf("ar_hs_v%0d", id), 32'(ar_hs), 32'(v.ops));
         chk($sformatf("ar_left_v%0d", id), 32'(q_exp_addr.size()), 0);
`ifdef RD_CHECKSUM_EN
         chk($sformatf("checksum_v%0d", id), rd_checksum, model_ck);
`endif
         @(negedge clk);
         chk($sformatf("done_pulse_v%0d", id), done, 0);
         chk($sformatf("busy_end_v%0d", id), busy, 0);
      end
      q_exp_addr.delete();
      rresp_beat = -1; flip_a = -1; flip_b = -1; r_rand = 0; ar_stall = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      //            ops strd      init         burst stall rnd rresp fa fb beats err len
      vecs[0] = '{4, 32'h100,  32'h0001000, 64,   0,   0,  -1,  -1,-1, 8,   0,  1};
      vecs[1] = '{6, 32'h40,   32'h0ABC000, 64,   3,   1,  -1,  -1,-1, 12,  0,  1};
      vecs[2] = '{2, 32'h100,  32'h0002000, 64,   0,   0,   1,   2, 3, 4,   3,  1};
      vecs[3] = '{5, 32'h20,   32'hFFFFFE0, 32,   0,   1,  -1,  -1,-1, 5,   0,  0};
      vecs[4] = '{3, 32'h1000, 32'h0000000, 256,  1,   0,  -1,  -1,-1, 24,  0,  7};
      vecs[5] = '{1, 32'h0,    32'h0000040, 128,  0,   0,  -1,  -1,-1, 4,   0,  3};

      // reset state
      @(negedge clk); @(negedge clk);
      chk("rst_arvalid", ARVALID, 0);
      chk("rst_araddr", ARADDR, 0);
      chk("rst_rready", RREADY, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_beats", beat_count, 0);
      chk("rst_errs", err_count, 0);
      chk("arsize", ARSIZE, 3'b101);
      chk("arburst", ARBURST, 2'b01);
      chk("arprot", ARPROT, 3'b010);
      chk("arid", ARID, 0);
      rst = 0;
      @(negedge clk);

      // first concrete address sequence of the basic run
      chk("calc_basic_addr3", calc_addr(32'h1000, 32'h100, 3), 33'h20001300);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // zero ops: immediate done, never busy, no address
      @(negedge clk);
      start_read = 1; read_ops = 0;
      @(negedge clk);
      start_read = 0;
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      chk("zero_arvalid", ARVALID, 0);
      chk("zero_beats_cleared", beat_count, 0);
      @(negedge clk);
      chk("zero_done_pulse", done, 0);
      chk("zero_arvalid2", ARVALID, 0);

      // outstanding limit with R held off, plus ignored start while busy
      ar_hs = 0; g_beat = 0; model_ck = '0; exp_arlen = 8'd1; r_block = 1;
      push_addrs(10, 32'h3000, 32'h80);
      start_read = 1; read_ops = 10; stride = 32'h80; init_addr = 33'h3000; mem_burst_size = 16'd64;
      @(negedge clk);
      start_read = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (c == 10) begin start_read = 1; read_ops = 1; end
         if (c == 11) begin start_read = 0; read_ops = 10; end
      end
      chk("limit_ar_hs", 32'(ar_hs), 4);
      chk("limit_arvalid_low", ARVALID, 0);
      chk("limit_busy", busy, 1);
      r_block = 0;
      wait_done("limit", seen);
      if (seen) begin
         chk("limit_ar_total", 32'(ar_hs), 10);
         chk("limit_beats", beat_count, 20);
         chk("limit_errs", err_count, 0);
      end
      q_exp_addr.delete();

      // asynchronous reset mid-run
      ar_hs = 0; g_beat = 0;
      push_addrs(8, 32'h5000, 32'h100);
      @(negedge clk);
      start_read = 1; read_ops = 8; stride = 32'h100; init_addr = 33'h5000; mem_burst_size = 16'd64;
      @(negedge clk);
      start_read = 0;
      repeat (4) @(negedge clk);
      #2 rst = 1;
      #1;
      chk("mid_rst_arvalid", ARVALID, 0);
      chk("mid_rst_rready", RREADY, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_beats", beat_count, 0);
      @(negedge clk);
      q_exp_addr.delete();
      rst = 0;
      @(negedge clk);
      chk("post_rst_rready", RREADY, 0);
      chk("post_rst_arvalid", ARVALID, 0);

      run_vec(vecs[0], 6);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hbm_stride_read.md
Name: hbm_stride_read

Overview:
- AXI4 read master for one HBM pseudo-channel; counterpart of the per-engine HBM write traffic generator.
- On start, issues `read_ops` INCR read bursts at `init_addr + k*stride` and accepts every R beat.
- Counts beats and bursts, reports RRESP/RLAST errors, and pulses done when the last burst completes.
- Sits beside the write generator on the same HBM port, for bandwidth measurement and read-back traffic.

Parameters:
- ENGINE_ID, 0: 4-bit engine select; placed in address bits [31:28].
- ADDR_WIDTH, 33: AXI address width.
- DATA_WIDTH, 256: AXI data width; only 256 or 512 supported.
- ID_WIDTH, 5: AXI ID width.
- MAX_OUTSTANDING, 16: maximum issued-but-incomplete bursts; power of two, ≤256.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start_read  in  1  one-cycle start pulse; ignored while busy
- read_ops  in  32  number of bursts
- stride  in  32  byte offset between consecutive burst addresses
- init_addr  in  ADDR_WIDTH  base address; only bits [27:0] used
- mem_burst_size  in  16  bytes per burst
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the final R beat of the final burst is accepted
- beat_count  out  32  R beats accepted this run
- err_count  out  16  beats with RRESP!=0, plus RLAST mismatches
- m_axi_ARVALID  out  1  read address valid
- m_axi_ARADDR  out  ADDR_WIDTH  read byte address
- m_axi_ARID  out  ID_WIDTH  constant 0
- m_axi_ARLEN  out  8  beats-1
- m_axi_ARSIZE  out  3  3'b101 for 256-bit, 3'b110 for 512-bit
- m_axi_ARBURST  out  2  2'b01 (INCR)
- m_axi_ARLOCK  out  2  2'b00
- m_axi_ARCACHE  out  4  4'b0000
- m_axi_ARPROT  out  3  3'b010
- m_axi_ARQOS  out  4  4'b0000
- m_axi_ARREGION  out  4  4'b0000
- m_axi_ARREADY  in  1  address accepted
- m_axi_RVALID  in  1  read data valid
- m_axi_RDATA  in  DATA_WIDTH  read data
- m_axi_RRESP  in  2  read response
- m_axi_RLAST  in  1  last beat of burst
- m_axi_RID  in  ID_WIDTH  read ID; not checked
- m_axi_RREADY  out  1  read data ready

Behaviour:
- Reset (async, rst=1): state IDLE; ARVALID=0, ARADDR=0, RREADY=0, busy=0, done=0; beat_count, err_count, all internal counters =0.
- Start capture: on start_read in IDLE, register read_ops, stride, mem_burst_size and base={1'b0, ENGINE_ID[3:0], init_addr[27:0]}. Clear offset, ar_cnt, burst_cnt, beat_in_burst, beat_count, err_count, outstanding.
- ARLEN = (mem_burst_size >> log2(DATA_WIDTH/8)) - 1, truncated to 8 bits. mem_burst_size=32 at 256-bit gives ARLEN=0.
- Other AR fields are registered constants, valid out of reset.
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN on start_read with read_ops!=0.
- IDLE with start_read and read_ops==0: no AR is issued; done pulses 1 cycle after start; busy stays 0.
- RUN: ARVALID=1 while ar_cnt<read_ops and outstanding<MAX_OUTSTANDING.
  - ARADDR = base + offset, modulo 2^ADDR_WIDTH.
  - ARADDR and ARVALID are registered and held stable until ARREADY&ARVALID.
  - On each handshake: offset+=stride, ar_cnt++.
  - When ar_cnt reaches read_ops, go to DRAIN.
- RREADY=1 in RUN and DRAIN, 0 in IDLE.
- On each RVALID&RREADY:
  - beat_count++; err_count++ if RRESP!=0.
  - beat_in_burst++ and wraps at ARLEN.
  - RLAST expected exactly when beat_in_burst==ARLEN. A mismatch in either direction adds one to err_count, at most one per beat.
  - err_count saturates at 16'hFFFF.
- Burst completion: the beat where beat_in_burst==ARLEN completes a burst. burst_cnt++ and outstanding--.
- Outstanding counter: AR handshake increments, burst completion decrements. A simultaneous increment and decrement leaves it unchanged.
- Finish: completion of burst read_ops (in RUN or DRAIN) -> done=1 for 1 cycle (registered), busy=0, state IDLE. beat_count and err_count hold until the next start.
- start_read while busy: ignored, no effect.
- Reset mid-run: everything returns to reset values immediately. In-flight R beats after reset are not accepted (RREADY=0).
- R beats arriving in IDLE are not accepted.

Optional Feature:
- Macro RD_CHECKSUM_EN.
- Defined: adds output rd_checksum [DATA_WIDTH-1:0], cleared on reset and on accepted start. Each accepted beat XORs RDATA into it; the value is valid when done pulses.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Basic run: DATA_WIDTH=256, read_ops=4, stride=0x100, init_addr=0x1000, burst=64, ENGINE_ID=2, ARREADY=RVALID=1, slave returns RLAST correctly.
  -> ARADDR 0x20001000/1100/1200/1300, ARLEN=1, 8 beats, beat_count=8, err_count=0, one done pulse.
- Backpressure: ARREADY low 3 cycles per address, RVALID random 50%.
  -> ARADDR and ARVALID stable while stalled, no lost beats, beat_count=2*read_ops.
- Outstanding limit: MAX_OUTSTANDING=4, read_ops=10, RVALID held 0 for 50 cycles.
  -> exactly 4 AR handshakes, ARVALID drops; AR resumes after first burst completes.
- Errors: read_ops=2, burst=64; beat 1 RRESP=2'b10; second burst RLAST missing on beat 2 and asserted on beat 1.
  -> err_count=2 (RRESP on beat 1, RLAST asserted early on beat 1 of the second burst) plus 1 (RLAST missing on beat 2) = 3; done still pulses.
- Zero ops and re-start: read_ops=0 -> no ARVALID, done 1 cycle after start. start_read while busy is ignored. rst asserted mid-run -> ARVALID=0, RREADY=0, busy=0 asynchronously.
- RD_CHECKSUM_EN: 4 beats of data 0x1, 0x2, 0x4, 0x8 -> rd_checksum=0xF at done.
